instr_fetch_unit: RTL

//  Reader side of the instruction memory: owns the PC, drives the IMEM read address and samples the byte.

---
 rtl/core_pkg.sv | 29 ++
 rtl/jump_target_calc.sv | 16 +
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit core: opcodes, instruction field positions
// and the fetch-stage state encoding.
package core_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 6;
    localparam int IMM_MSB = 1;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    function automatic logic [1:0] get_op(input logic [7:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [1:0] get_imm(input logic [7:0] instr);
        return instr[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/jump_target_calc.sv
// Jump target = pc + 1 + sign-extended 2-bit immediate (mod 256), plus a flag
// for the self-jump idiom that marks program end.
module jump_target_calc (
    input  logic [7:0] pc,
    input  logic [1:0] imm,
    output logic [7:0] target,
    output logic       is_self
);

    logic [7:0] imm_sext;

    assign imm_sext = {{6{imm[1]}}, imm};
    assign target   = pc + 8'd1 + imm_sext;
    assign is_self  = (target == pc);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, folds jumps locally and issues add/lw/sw to decode
// through a one-entry valid/ready register.
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter logic [7:0] RESET_PC     = 8'h00,
    parameter bit         HALT_ON_SELF = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    output logic [7:0] Read_Address,
    input  logic [7:0] Instruction,
    output logic [7:0] IR,
    output logic [7:0] IR_PC,
    output logic       IR_Valid,
    input  logic       Dec_Ready,
    output logic       Halted,
    output logic [7:0] Fetch_Count
);

    fetch_state_t state, next_state;
    logic [7:0]   pc;
    logic [7:0]   jump_target;
    logic         jump_is_self;
    logic         is_jump;
    logic         slot_free;
    logic         fetch_en;
    logic         do_issue;
    logic         do_jump;
    logic         halt_jump;

    jump_target_calc u_jump_target_calc (
        .pc      (pc),
        .imm     (get_imm(Instruction)),
        .target  (jump_target),
        .is_self (jump_is_self)
    );

    assign Read_Address = pc;
    assign is_jump      = (get_op(Instruction) == OP_J);
    assign slot_free    = !IR_Valid || Dec_Ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Run) next_state = FETCH;
            FETCH:   if (halt_jump) next_state = HALT;
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        fetch_en  = (state == FETCH) && Run && slot_free;
        do_issue  = fetch_en && !is_jump;
        do_jump   = fetch_en && is_jump;
        halt_jump = do_jump && jump_is_self && HALT_ON_SELF;
        Halted    = (state == HALT);
    end

    // The self-jump that parks the unit leaves the PC on the halting jump.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc <= RESET_PC;
        end else if (do_issue) begin
            pc <= pc + 8'd1;
        end else if (do_jump && !halt_jump) begin
            pc <= jump_target;
        end
    end

    // Refill wins over drain, so a transfer and a new issue share one edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            IR          <= 8'h00;
            IR_PC       <= 8'h00;
            IR_Valid    <= 1'b0;
            Fetch_Count <= 8'h00;
        end else begin
            if (do_issue) begin
                IR          <= Instruction;
                IR_PC       <= pc;
                IR_Valid    <= 1'b1;
                Fetch_Count <= Fetch_Count + 8'd1;
            end else if (Dec_Ready) begin
                IR_Valid <= 1'b0;
            end
        end
    end

endmodule
